// File: rtl/load_store_unit_if.sv
// load_store_unit_if: groups the datapath request/response handshake and the
// data-memory port of the load/store unit into one bundle.
// The slave modport is the load/store unit itself. The master modport is its
// environment: the datapath on the request side and the memory on the memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_sign_ext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_store, req_size, req_sign_ext, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_write_data, mem_write_enable, mem_read_enable
  );

  modport master (
    output req_valid, req_store, req_size, req_sign_ext, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_write_data, mem_write_enable, mem_read_enable
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: turns byte-addressed byte/halfword/word loads and stores
// into accesses on a word-addressed 32-bit memory. Sub-word stores are done
// as read-modify-write. Every output is driven straight from a flop, so the
// level-sensitive memory write enable can never glitch.
// Optional feature: define LSU_ALIGN_CHECK_EN to report misaligned halfword
// and word accesses as errors. Without it, the low address bits those sizes
// do not use are ignored.
module load_store_unit #(
  parameter int MEM_WORDS = 512
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [29:0] MEM_WORDS_IDX = 30'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        store_q, store_d;
  logic        sign_q, sign_d;
  logic [31:0] wdata_q, wdata_d;

  logic        ready_q, ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;

  logic        req_err;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Decode whether the request on the bus is illegal (bad size, out of range, misaligned)
  always_comb begin
    req_err = (bus.req_size == 2'b11) || (bus.req_addr[31:2] >= MEM_WORDS_IDX);
`ifdef LSU_ALIGN_CHECK_EN
    if ((bus.req_size == 2'b01) && bus.req_addr[0])
      req_err = 1'b1;
    if ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  // Lane extraction for loads and lane merge for sub-word stores on the word just read
  always_comb begin
    byte_lane = 8'(bus.mem_read_data >> {off_q, 3'b000});
    half_lane = 16'(bus.mem_read_data >> {off_q[1], 4'b0000});
    case (size_q)
      2'b00:   load_val = sign_q ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
      2'b01:   load_val = sign_q ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
      default: load_val = bus.mem_read_data;
    endcase
    merged = bus.mem_read_data;
    case (size_q)
      2'b00:   merged[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
      2'b01:   merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Next-state and next-output logic; every output flop is loaded from its value in the coming state
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    store_d      = store_q;
    sign_d       = sign_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_error_d = 1'b0;
    resp_rdata_d = 32'h0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          off_d      = bus.req_addr[1:0];
          size_d     = bus.req_size;
          store_d    = bus.req_store;
          sign_d     = bus.req_sign_ext;
          wdata_d    = bus.req_wdata;
          mem_addr_d = {2'b00, bus.req_addr[31:2]};
          if (req_err) begin
            state_d      = RESP;
            resp_error_d = 1'b1;
          end else if (bus.req_store && (bus.req_size == 2'b10)) begin
            state_d     = WRITE;
            mem_wdata_d = bus.req_wdata;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (store_q) begin
          state_d     = WRITE;
          mem_wdata_d = merged;
        end else begin
          state_d      = RESP;
          resp_rdata_d = load_val;
        end
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase

    ready_d      = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    mem_re_d     = (state_d == READ);
    mem_we_d     = (state_d == WRITE);
  end

  // State and registered outputs; reset abandons any access and drops the memory enables at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      store_q      <= 1'b0;
      sign_q       <= 1'b0;
      wdata_q      <= 32'h0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      store_q      <= store_d;
      sign_q       <= sign_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
    end
  end

  assign bus.req_ready        = ready_q;
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_error       = resp_error_q;
  assign bus.resp_rdata       = resp_rdata_q;
  assign bus.mem_address      = mem_addr_q;
  assign bus.mem_write_data   = mem_wdata_q;
  assign bus.mem_write_enable = mem_we_q;
  assign bus.mem_read_enable  = mem_re_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed test of load_store_unit against a small word
// memory model. Each transaction is tracked from acceptance to its response.
module tb_load_store_unit;

  logic clk;
  logic rst;
  logic mem_init;

  load_store_unit_if bus();

  load_store_unit #(.MEM_WORDS(512)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:511];

  int          tests_run;
  int          tests_failed;
  int          obs_lat;
  int          obs_re;
  int          obs_we;
  logic        obs_resp;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic [31:0] obs_wa;
  logic [31:0] obs_wd;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory read; addresses past the end read as zero
  assign bus.mem_read_data = (bus.mem_address < 32'd512) ? mem[bus.mem_address[8:0]] : 32'h0;

  // Memory model: preload when mem_init is set, otherwise accept writes on the clock edge
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      mem[1] <= 32'd2;
      mem[2] <= 32'd4;
      mem[3] <= 32'd5;
    end else if (bus.mem_write_enable && (bus.mem_address < 32'd512)) begin
      mem[bus.mem_address[8:0]] <= bus.mem_write_data;
    end
  end

  // Compare one observed value with its expected value and count the result
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issue one request and follow it until resp_valid, recording latency and memory activity
  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic sx,
                               input logic [31:0] a, input logic [31:0] wd);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) checkOutput("ready_timeout", 32'h0, 32'h1);
    bus.req_store    = st;
    bus.req_size     = sz;
    bus.req_sign_ext = sx;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    obs_lat   = 0;
    obs_re    = 0;
    obs_we    = 0;
    obs_resp  = 1'b0;
    obs_rdata = 32'hx;
    obs_err   = 1'bx;
    obs_wa    = 32'hx;
    obs_wd    = 32'hx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.mem_read_enable) obs_re++;
      if (bus.mem_write_enable) begin
        obs_we++;
        obs_wa = bus.mem_address;
        obs_wd = bus.mem_write_data;
      end
      if (bus.resp_valid) begin
        obs_lat   = c;
        obs_rdata = bus.resp_rdata;
        obs_err   = bus.resp_error;
        obs_resp  = 1'b1;
        break;
      end
    end
    if (!obs_resp) checkOutput("resp_timeout", 32'h0, 32'h1);
  endtask

  // Check the response of the last transaction: latency, data, error and enable counts
  task automatic checkTxn(input string tag, input int lat, input logic [31:0] rdata,
                          input logic err, input int re, input int we);
    checkOutput({tag, "_lat"},   32'(obs_lat), 32'(lat));
    checkOutput({tag, "_rdata"}, obs_rdata, rdata);
    checkOutput({tag, "_err"},   {31'h0, obs_err}, {31'h0, err});
    checkOutput({tag, "_re"},    32'(obs_re), 32'(re));
    checkOutput({tag, "_we"},    32'(obs_we), 32'(we));
  endtask

  // Main directed sequence
  initial begin
    int seen;
    tests_run        = 0;
    tests_failed     = 0;
    rst              = 1'b1;
    mem_init         = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_store    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_sign_ext = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    repeat (3) @(negedge clk);

    checkOutput("rst_ready",  {31'h0, bus.req_ready}, 32'h1);
    checkOutput("rst_rvalid", {31'h0, bus.resp_valid}, 32'h0);
    checkOutput("rst_rerr",   {31'h0, bus.resp_error}, 32'h0);
    checkOutput("rst_rdata",  bus.resp_rdata, 32'h0);
    checkOutput("rst_we",     {31'h0, bus.mem_write_enable}, 32'h0);
    checkOutput("rst_re",     {31'h0, bus.mem_read_enable}, 32'h0);
    checkOutput("rst_maddr",  bus.mem_address, 32'h0);
    checkOutput("rst_mwdata", bus.mem_write_data, 32'h0);
    rst      = 1'b0;
    mem_init = 1'b0;

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
    checkTxn("lw_0c", 2, 32'd5, 1'b0, 1, 0);

    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_0009, 32'hFFFF_FFAB);
    checkTxn("sb_09", 3, 32'h0, 1'b0, 1, 1);
    checkOutput("sb_09_waddr", obs_wa, 32'd2);
    checkOutput("sb_09_wdata", obs_wd, 32'h0000_AB04);

    applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_0009, 32'h0);
    checkTxn("lb_09_s", 2, 32'hFFFF_FFAB, 1'b0, 1, 0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_0009, 32'h0);
    checkTxn("lb_09_u", 2, 32'h0000_00AB, 1'b0, 1, 0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_0008, 32'h0);
    checkTxn("lh_08_s", 2, 32'hFFFF_AB04, 1'b0, 1, 0);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    checkTxn("sw_10", 2, 32'h0, 1'b0, 0, 1);
    checkOutput("sw_10_mem", mem[4], 32'hDEAD_BEEF);

    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h1234_CAFE);
    checkTxn("sh_12", 3, 32'h0, 1'b0, 1, 1);
    checkOutput("sh_12_mem", mem[4], 32'hCAFE_BEEF);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0);
    checkTxn("lh_12_u", 2, 32'h0000_CAFE, 1'b0, 1, 0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0);
    checkTxn("lb_13_s", 2, 32'hFFFF_FFCA, 1'b0, 1, 0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0);
    checkTxn("lb_10_s", 2, 32'hFFFF_FFEF, 1'b0, 1, 0);

`ifdef LSU_ALIGN_CHECK_EN
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
    checkTxn("lw_06", 1, 32'h0, 1'b1, 0, 0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h5555);
    checkTxn("sh_11", 1, 32'h0, 1'b1, 0, 0);
`else
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
    checkTxn("lw_06", 2, 32'd2, 1'b0, 1, 0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0);
    checkTxn("lh_11", 2, 32'h0000_BEEF, 1'b0, 1, 0);
`endif

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0800, 32'h0);
    checkTxn("lw_800", 1, 32'h0, 1'b1, 0, 0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h0000_000C, 32'h0);
    checkTxn("size_11", 1, 32'h0, 1'b1, 0, 0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0800, 32'h1111_1111);
    checkTxn("sw_800", 1, 32'h0, 1'b1, 0, 0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_07FF, 32'h0000_0066);
    checkTxn("sb_7ff", 3, 32'h0, 1'b0, 1, 1);
    checkOutput("sb_7ff_mem", mem[511], 32'h6600_0000);

    // Reset in the WRITE cycle of a sub-word store
    @(negedge clk);
    bus.req_store    = 1'b1;
    bus.req_size     = 2'b00;
    bus.req_sign_ext = 1'b0;
    bus.req_addr     = 32'h0000_000A;
    bus.req_wdata    = 32'h0000_0077;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    seen = 0;
    while (!bus.mem_write_enable && seen < 6) begin
      @(negedge clk);
      seen++;
    end
    checkOutput("rstw_reach_write", {31'h0, bus.mem_write_enable}, 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstw_we",     {31'h0, bus.mem_write_enable}, 32'h0);
    checkOutput("rstw_ready",  {31'h0, bus.req_ready}, 32'h1);
    checkOutput("rstw_rvalid", {31'h0, bus.resp_valid}, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    checkOutput("rstw_no_resp", 32'(seen), 32'h0);
    checkOutput("rstw_mem", mem[2], 32'h0000_AB04);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0);
    checkTxn("lw_08_after_rst", 2, 32'h0000_AB04, 1'b0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
